line_delay_buffer: RTL and testbench



---
 rtl/line_delay_buffer.sv | 82 ++++++++
 tb/tb_line_delay_buffer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/line_delay_buffer.sv
// One image row of a 3x3 window delay line: NTAPS exposed pixel registers
// followed by a circular-buffer delay so the whole line is NTAPS+FIFOSIZE stages.
module line_delay_buffer #(
   parameter int WIDTH    = 12,
   parameter int NTAPS    = 3,
   parameter int FIFOSIZE = 637
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         datain,
   output logic [NTAPS*WIDTH-1:0]   taps,
   output logic [WIDTH-1:0]         dataout,
   output logic                     primed
);

   localparam int LINE_LEN = NTAPS + FIFOSIZE;
   localparam int CW       = $clog2(LINE_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(LINE_LEN - 1);

   logic [WIDTH-1:0] tap_p0 [NTAPS];
   logic [WIDTH-1:0] dout_p1;
   logic [CW-1:0]    fill_cnt;
   logic             vld_p1;

   // Stage p0: exposed window taps, tap 0 newest
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) tap_p0[i] <= '0;
      end else begin
         tap_p0[0] <= datain;
         for (int i = 1; i < NTAPS; i++) tap_p0[i] <= tap_p0[i-1];
      end
   end

   for (genvar g = 0; g < NTAPS; g++) begin : g_taps
      assign taps[g*WIDTH +: WIDTH] = tap_p0[g];
   end

   // Stage p1: FIFO section, FIFOSIZE cycles from last tap to dout_p1
   if (FIFOSIZE == 1) begin : g_single
      always_ff @(posedge clk) begin
         if (reset) dout_p1 <= '0;
         else       dout_p1 <= tap_p0[NTAPS-1];
      end
   end else begin : g_ram
      // Read-before-write RAM of depth FIFOSIZE-1 plus the output register
      // gives exactly FIFOSIZE cycles for any depth, power of two or not.
      localparam int DEPTH = FIFOSIZE - 1;
      localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    ptr;

      always_ff @(posedge clk) begin
         if (reset)                 ptr <= '0;
         else if (ptr == PTR_LAST)  ptr <= '0;
         else                       ptr <= ptr + 1'b1;
      end

      always_ff @(posedge clk) begin
         dout_p1  <= mem[ptr];
         mem[ptr] <= tap_p0[NTAPS-1];
      end
   end

   // Fill counter: the RAM is never cleared, so its output is masked until
   // the first post-reset sample has travelled the full line.
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_cnt <= '0;
         vld_p1   <= 1'b0;
      end else if (!vld_p1) begin
         if (fill_cnt == CNT_LAST) vld_p1   <= 1'b1;
         else                      fill_cnt <= fill_cnt + 1'b1;
      end
   end

   assign dataout = vld_p1 ? dout_p1 : '0;
   assign primed  = vld_p1;

endmodule

// File: tb/tb_line_delay_buffer.sv
// Randomized/directed bench for line_delay_buffer: several parameter sets plus a
// two-line cascade, checked against a history-of-samples-since-reset model.
module tb_line_delay_buffer;

   logic        clk;
   logic        reset;
   logic [11:0] din;

   logic [35:0] a_taps, b_taps, c_taps, b2_taps;
   logic [11:0] e_taps;
   logic [11:0] a_dout, b_dout, c_dout, e_dout, b2_dout;
   logic        a_pr, b_pr, c_pr, e_pr, b2_pr;

   line_delay_buffer #(.WIDTH(12), .NTAPS(3), .FIFOSIZE(4)) dut_a (
      .clk(clk), .reset(reset), .datain(din), .taps(a_taps), .dataout(a_dout), .primed(a_pr));
   line_delay_buffer dut_b (
      .clk(clk), .reset(reset), .datain(din), .taps(b_taps), .dataout(b_dout), .primed(b_pr));
   line_delay_buffer #(.WIDTH(12), .NTAPS(3), .FIFOSIZE(5)) dut_c (
      .clk(clk), .reset(reset), .datain(din), .taps(c_taps), .dataout(c_dout), .primed(c_pr));
   line_delay_buffer #(.WIDTH(12), .NTAPS(1), .FIFOSIZE(1)) dut_e (
      .clk(clk), .reset(reset), .datain(din), .taps(e_taps), .dataout(e_dout), .primed(e_pr));
   line_delay_buffer dut_b2 (
      .clk(clk), .reset(reset), .datain(b_dout), .taps(b2_taps), .dataout(b2_dout), .primed(b2_pr));

   typedef struct {
      logic [35:0] a_t, b_t, c_t, b2_t;
      logic [11:0] e_t;
      logic [11:0] a_d, b_d, c_d, e_d, b2_d;
      logic [4:0]  pr;
   } exp_t;

   exp_t        sbq[$];
   logic [11:0] hist[$];   // samples captured since last reset, newest first
   int          total = 0;
   int          bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] h(input int i);
      if (i < hist.size()) return hist[i];
      return 12'h000;
   endfunction

   function automatic logic [35:0] tp3(input int base);
      return {h(base + 2), h(base + 1), h(base)};
   endfunction

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Apply one input cycle, then advance the model across the same edge.
   task automatic step(input logic r, input logic [11:0] d);
      exp_t e;
      int   sz;
      reset = r;
      din   = d;
      @(posedge clk);
      if (r) hist.delete();
      else begin
         hist.push_front(d);
         if (hist.size() > 1280) void'(hist.pop_back());
      end
      sz     = hist.size();
      e.a_t  = tp3(0);   e.a_d  = h(6);
      e.b_t  = tp3(0);   e.b_d  = h(639);
      e.c_t  = tp3(0);   e.c_d  = h(7);
      e.e_t  = h(0);     e.e_d  = h(1);
      e.b2_t = tp3(640); e.b2_d = h(1279);
      e.pr   = {sz >= 640, sz >= 2, sz >= 8, sz >= 640, sz >= 7};
      sbq.push_back(e);
      #1;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            check("a_taps",  a_taps,  x.a_t);
            check("a_dout",  {24'h0, a_dout},  {24'h0, x.a_d});
            check("b_taps",  b_taps,  x.b_t);
            check("b_dout",  {24'h0, b_dout},  {24'h0, x.b_d});
            check("c_taps",  c_taps,  x.c_t);
            check("c_dout",  {24'h0, c_dout},  {24'h0, x.c_d});
            check("e_taps",  {24'h0, e_taps},  {24'h0, x.e_t});
            check("e_dout",  {24'h0, e_dout},  {24'h0, x.e_d});
            check("b2_taps", b2_taps, x.b2_t);
            check("b2_dout", {24'h0, b2_dout}, {24'h0, x.b2_d});
            check("primed",  {31'h0, b2_pr, e_pr, c_pr, b_pr, a_pr}, {31'h0, x.pr});
         end
      end
   end

   initial begin : stimulus
      reset = 1'b1;
      din   = 12'h000;
      step(1'b1, 12'h000);
      step(1'b1, 12'h000);
      // ramp from the first edge after reset
      for (int i = 1; i <= 1300; i++) step(1'b0, 12'(i));
      // impulse
      step(1'b1, 12'h000);
      step(1'b0, 12'hABC);
      repeat (700) step(1'b0, 12'h000);
      // random stream, mid-stream reset, constant stream
      step(1'b1, 12'h000);
      repeat (1000) step(1'b0, 12'($urandom));
      step(1'b1, 12'h000);
      repeat (700) step(1'b0, 12'h555);
      // long random stream to exercise the cascade and many pointer wraps
      repeat (1400) step(1'b0, 12'($urandom));
      for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
